// File: rtl/viterbi_pkg.sv
// Shared Viterbi decoder definitions: trellis geometry, traceback FSM states
// and the predecessor-state rule used by both path-metric and traceback stages.
package viterbi_pkg;

    localparam int NSTATES = 8;
    localparam int STATE_W = 3;
    localparam int DEPTH   = 64;
    localparam int ADDR_W  = 6;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        CAP,
        OUT
    } tb_state_e;

    // Next state is {n[1:0], u}, so the survivor bit s re-inserts the dropped MSB.
    function automatic logic [STATE_W-1:0] pred_state(input logic [STATE_W-1:0] n,
                                                       input logic s);
        return {s, n[STATE_W-1:1]};
    endfunction

endpackage

// File: rtl/tb_bit_buffer.sv
// DEPTH x 1 decoded-bit register file: one synchronous write port and one
// combinational read port.
module tb_bit_buffer #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_idx_i,
    input  logic              wr_data_i,
    input  logic [ADDR_W-1:0] rd_idx_i,
    output logic              rd_data_o
);

    logic [DEPTH-1:0] bits_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bits_q <= '0;
        end else if (wr_en_i) begin
            bits_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = bits_q[rd_idx_i];

endmodule

// File: rtl/traceback_unit.sv
// Viterbi survivor-memory traceback: walks DEPTH steps back from start_state and
// streams the decoded frame over valid/ready. Macro TB_FWD_ORDER_EN selects forward output order.
import viterbi_pkg::*;

module traceback_unit #(
    parameter int DEPTH   = viterbi_pkg::DEPTH,
    parameter int ADDR_W  = viterbi_pkg::ADDR_W,
    parameter int NSTATES = viterbi_pkg::NSTATES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [STATE_W-1:0] start_state,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [NSTATES-1:0] mem_data,
    output logic               out_valid,
    output logic               out_bit,
    output logic               out_last,
    input  logic               out_ready,
    output logic               busy
);

    tb_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  rd_idx_q, rd_idx_d;
    logic [ADDR_W:0]    cnt_q, cnt_d;
    logic [STATE_W-1:0] cur_q, cur_d;
    logic               buf_we;
    logic               buf_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            addr_q   <= '0;
            rd_idx_q <= '0;
            cnt_q    <= '0;
            cur_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            addr_q   <= addr_d;
            rd_idx_q <= rd_idx_d;
            cnt_q    <= cnt_d;
            cur_q    <= cur_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        addr_d    = addr_q;
        rd_idx_d  = rd_idx_q;
        cnt_d     = cnt_q;
        cur_d     = cur_q;
        buf_we    = 1'b0;
        mem_rd_en = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cur_d   = start_state;
                    ptr_d   = ADDR_W'(DEPTH - 1);
                    state_d = RD;
                end
            end
            RD: begin
                mem_rd_en = 1'b1;
                addr_d    = ptr_q;
                state_d   = CAP;
            end
            CAP: begin
                // Survivor vector for ptr_q arrives this cycle.
                buf_we = 1'b1;
                cur_d  = pred_state(cur_q, mem_data[cur_q]);
                if (ptr_q == '0) begin
                    cnt_d   = '0;
`ifdef TB_FWD_ORDER_EN
                    rd_idx_d = '0;
`else
                    rd_idx_d = ADDR_W'(DEPTH - 1);
`endif
                    state_d = OUT;
                end else begin
                    ptr_d   = ptr_q - ADDR_W'(1);
                    state_d = RD;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
`ifdef TB_FWD_ORDER_EN
                    rd_idx_d = rd_idx_q + ADDR_W'(1);
`else
                    rd_idx_d = rd_idx_q - ADDR_W'(1);
`endif
                    if (cnt_q == (ADDR_W+1)'(DEPTH - 1)) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + (ADDR_W+1)'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Address is live during RD and held afterwards.
    assign mem_addr = mem_rd_en ? ptr_q : addr_q;
    assign out_bit  = out_valid & buf_bit;
    assign out_last = out_valid && (cnt_q == (ADDR_W+1)'(DEPTH - 1));
    assign busy     = (state_q != IDLE);

    tb_bit_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (buf_we),
        .wr_idx_i  (ptr_q),
        .wr_data_i (cur_q[0]),
        .rd_idx_i  (rd_idx_q),
        .rd_data_o (buf_bit)
    );

endmodule

// File: doc/traceback_unit.md
# traceback_unit

Survivor-memory reader for the Viterbi decoder. It runs after the path-metric stage has written one full frame of 8-bit survivor vectors, at addresses 0..DEPTH-1. Starting from the minimum-error state, it walks the survivor memory backwards, recovers one decoded bit per trellis step, and streams the frame out through a valid/ready interface.

## Interface
Parameters:
- DEPTH, 64, trellis steps per frame; also the survivor-memory depth.
- ADDR_W, 6, survivor-memory address width; equals clog2(DEPTH).
- NSTATES, 8, trellis states; also the survivor vector width.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  one-cycle pulse: frame complete, begin traceback.
- start_state  in  3  state with the least accumulated error; sampled on an accepted start.
- mem_rd_en  out  1  survivor-memory read strobe.
- mem_addr  out  ADDR_W  survivor-memory read address.
- mem_data  in  NSTATES  survivor vector; valid exactly one cycle after mem_rd_en.
- out_valid  out  1  out_bit is valid.
- out_bit  out  1  decoded bit.
- out_last  out  1  final bit of the frame; qualified by out_valid.
- out_ready  in  1  downstream accepts the bit when out_valid and out_ready are both high.
- busy  out  1  high in every FSM state except IDLE.

## Operation
Trellis convention:
- States n = 0..7; next state = {n[1:0], u}, where u is the input bit.
- The decoded bit for a step whose end state is n is n[0].
- The survivor bit s = mem_data[n] selects the predecessor {s, n[2:1]}.

FSM states and transitions:
- IDLE: start accepted → cur_state ← start_state, ptr ← DEPTH-1, go to RD. start while busy is ignored.
- RD: mem_rd_en=1, mem_addr=ptr → CAP.
- CAP: mem_data is valid this cycle.
  - buf[ptr] ← cur_state[0]; cur_state ← {mem_data[cur_state], cur_state[2:1]}.
  - ptr==0 → OUT, with the read index initialised per the configuration below.
  - otherwise ptr ← ptr-1 → RD.
- OUT: out_valid=1, out_bit = buf[rd_idx]. On each handshake the read index advances.
  - out_last=1 on the DEPTH-th bit.
  - The handshake on the last bit → IDLE.

Rules:
- ptr is ADDR_W bits. The down-count from DEPTH-1 to 0 never wraps, because the exit is taken at 0.
- The output count is a (ADDR_W+1)-bit counter, so DEPTH itself is representable.
- A frame is always exactly DEPTH bits; there are no partial frames.

## Timing
Reset values:
- mem_rd_en=0, mem_addr=0, out_valid=0, out_bit=0, out_last=0, busy=0, FSM=IDLE.
- ptr, counters, cur_state and buf cleared to 0.

Latency and throughput:
- start → first mem_rd_en: 1 cycle.
- Traceback: 2 cycles per step, 2·DEPTH cycles in total (128 at default).
- First out_valid appears the cycle after the last CAP.
- Output rate is 1 bit/cycle while out_ready=1.

Handshake and outputs:
- out_valid stays high and out_bit/out_last stay stable while out_ready=0.
- mem_addr holds its last value when mem_rd_en=0.

Boundary conditions:
- start and out_ready in the same cycle as the last handshake: the start is ignored, because the FSM is still busy that cycle.
- rst asserted mid-traceback or mid-output: the frame is aborted immediately, with no further reads and no partial output.

## Configuration
Macro TB_FWD_ORDER_EN:
- Defined: bits are emitted in forward time order, buf[0] first through buf[DEPTH-1].
- Undefined: bits are emitted in traceback order, buf[DEPTH-1] first down to buf[0]. The downstream block reverses them.
- out_last marks the DEPTH-th emitted bit in both cases. Timing is identical in both builds.

## Structure
Package viterbi_pkg holds:
- constants NSTATES=8, STATE_W=3, DEPTH=64, ADDR_W=6;
- the FSM state enum (IDLE, RD, CAP, OUT);
- a pred_state(n, s) function shared with the path-metric stage.

One sub-module, tb_bit_buffer:
- DEPTH×1 register file with a write port (index, data, enable) and a combinational read port (index).
- It is instantiated once.

## Test plan
- Memory all 0x00, start_state=0 → 128 cycles with mem_addr 63..0, each read once; then 64 zero bits; out_last only on the 64th bit.
- Memory all 0x00, start_state=1 → traceback to state 0 after one step.
  - TB_FWD_ORDER_EN defined: 63 zeros, then 1 with out_last.
  - Undefined: 1 first, then 63 zeros.
- Memory all 0xFF, start_state=7 → all 64 bits = 1; state stays 7 at every step.
- out_ready toggled 1-0-0-1 during OUT → no bit lost or duplicated; out_bit stable during the stall; exactly 64 handshakes.
- start pulsed during RD/CAP and again during OUT → both ignored; busy stays 1; a single frame is output.
- rst pulsed at step 30 of traceback → busy=0, mem_rd_en=0, out_valid=0 immediately. A subsequent start produces a full correct frame.
